// File: rtl/logic_unit_pkg.sv
// Shared op codes for the pipelined bitwise logic unit.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise op decode; the single home of the op encoding.
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [OP_W-1:0] op,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    output logic [N-1:0]    y
);

    always_comb begin
        y = a;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_NAND: y = ~(a & b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with accumulator chaining and valid/ready on both sides.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic            acc_en,
    input  logic [N-1:0]    A,
    input  logic [N-1:0]    B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    C,
    output logic            zero,
    output logic            all_ones
);

    logic            r_vld_p1;
    logic [OP_W-1:0] r_op_p1;
    logic            r_acc_en_p1;
    logic [N-1:0]    r_a_p1;
    logic [N-1:0]    r_b_p1;

    logic            r_vld_p2;
    logic [N-1:0]    r_c_p2;
    logic            r_zero_p2;
    logic            r_all_p2;
    logic [N-1:0]    r_acc;

    logic            w_adv2;
    logic            w_xfer;
    logic            w_accept;
    logic [N-1:0]    w_a_eff;
    logic [N-1:0]    w_y;

    assign w_adv2   = !r_vld_p2 || out_ready;
    assign w_xfer   = r_vld_p1 && w_adv2;
    assign in_ready = !r_vld_p1 || w_adv2;
    assign w_accept = in_valid && in_ready;

    // acc always holds the last S2 result, so chained accumulate beats see it without a bubble
    assign w_a_eff  = r_acc_en_p1 ? r_acc : r_a_p1;

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1    <= 1'b0;
            r_op_p1     <= '0;
            r_acc_en_p1 <= 1'b0;
            r_a_p1      <= '0;
            r_b_p1      <= '0;
        end else if (w_accept) begin
            r_vld_p1    <= 1'b1;
            r_op_p1     <= op;
            r_acc_en_p1 <= acc_en;
            r_a_p1      <= A;
            r_b_p1      <= B;
        end else if (w_xfer) begin
            r_vld_p1    <= 1'b0;
        end
    end

    logic_op_core #(
        .N (N)
    ) u_core (
        .op (r_op_p1),
        .a  (w_a_eff),
        .b  (r_b_p1),
        .y  (w_y)
    );

    // Stage 2: result, flags and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_c_p2    <= '0;
            r_zero_p2 <= 1'b0;
            r_all_p2  <= 1'b0;
            r_acc     <= '0;
        end else if (w_xfer) begin
            r_vld_p2  <= 1'b1;
            r_c_p2    <= w_y;
            r_zero_p2 <= ~|w_y;
            r_all_p2  <= &w_y;
            r_acc     <= w_y;
        end else if (out_ready) begin
            r_vld_p2  <= 1'b0;
        end
    end

    assign out_valid = r_vld_p2;
    assign C         = r_c_p2;
    assign zero      = r_zero_p2;
    assign all_ones  = r_all_p2;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-table and randomised-handshake bench for logic_unit_pipe (N=8).
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic         acc_en;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] C;
    logic         zero;
    logic         all_ones;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] op;
        logic       ae;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       z;
        logic       o;
    } vec_t;

    vec_t tbl[13];

    logic_unit_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_en    (acc_en),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .zero      (zero),
        .all_ones  (all_ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic ae,
                         input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        op       = o;
        acc_en   = ae;
        A        = a;
        B        = b;
    endtask

    task automatic do_reset();
        drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a | b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Back-to-back stream of table entries with the sink always ready.
    task automatic run_table(input int start, input int count);
        out_ready = 1'b1;
        for (int i = 0; i <= count; i++) begin
            if (i < count) begin
                drive(1'b1, tbl[start+i].op, tbl[start+i].ae, tbl[start+i].a, tbl[start+i].b);
                #1;
                check("tbl_in_ready", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i == 0) begin
                check("tbl_first_not_valid", out_valid, 0);
            end else begin
                check("tbl_out_valid", out_valid, 1);
                check("tbl_C", C, tbl[start+i-1].c);
                check("tbl_zero", zero, tbl[start+i-1].z);
                check("tbl_all_ones", all_ones, tbl[start+i-1].o);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] m_acc;
        logic [7:0] e;
        int         acc_cnt;
        int         sent;
        int         recv;
        int         cyc;
        logic       af;
        logic       of;

        tbl[0]  = '{OP_AND,  1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        tbl[1]  = '{OP_OR,   1'b0, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0};
        tbl[2]  = '{OP_XOR,  1'b0, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0};
        tbl[3]  = '{OP_NOR,  1'b0, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0};
        tbl[4]  = '{OP_NAND, 1'b0, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0};
        tbl[5]  = '{OP_XNOR, 1'b0, 8'hF0, 8'h3C, 8'h33, 1'b0, 1'b0};
        tbl[6]  = '{OP_NOTA, 1'b0, 8'hF0, 8'h3C, 8'h0F, 1'b0, 1'b0};
        tbl[7]  = '{OP_PASS, 1'b0, 8'hF0, 8'h3C, 8'hF0, 1'b0, 1'b0};
        tbl[8]  = '{OP_XOR,  1'b0, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0};
        tbl[9]  = '{OP_NOR,  1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1};
        tbl[10] = '{OP_OR,   1'b1, 8'h55, 8'h01, 8'h01, 1'b0, 1'b0};
        tbl[11] = '{OP_OR,   1'b1, 8'hC3, 8'h80, 8'h81, 1'b0, 1'b0};
        tbl[12] = '{OP_XOR,  1'b1, 8'h99, 8'hFF, 8'h7E, 1'b0, 1'b0};

        out_ready = 1'b1;
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_C", C, 0);
        check("rst_zero", zero, 0);
        check("rst_all_ones", all_ones, 0);

        run_table(0, 10);

        do_reset();
        run_table(10, 3);

        // Backpressure: sink stalled while the source keeps offering
        do_reset();
        out_ready = 1'b0;
        acc_cnt   = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, OP_PASS, 1'b0, 8'h10 + 8'(acc_cnt), 8'h00);
            #1;
            if (c >= 2) check("bp_in_ready_low", in_ready, 0);
            if (in_ready) acc_cnt++;
            tick();
            if (c >= 1) begin
                check("bp_out_valid", out_valid, 1);
                check("bp_C_held", C, 8'h10);
            end
        end
        check("bp_accepted", acc_cnt, 2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_rel_valid", out_valid, 1);
        check("bp_rel_C", C, 8'h11);
        tick();
        check("bp_drained", out_valid, 0);
        run_table(0, 3);

        // Random handshake against an in-order reference queue
        do_reset();
        m_acc = 8'h00;
        sent  = 0;
        recv  = 0;
        cyc   = 0;
        while (recv < 1000 && cyc < 20000) begin
            drive((sent < 1000) && ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            af = in_valid && in_ready;
            of = out_valid && out_ready;
            if (of) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_C", C, e);
                    check("rnd_zero", zero, (e == 8'h00));
                    check("rnd_all_ones", all_ones, (e == 8'hFF));
                end
                recv++;
            end
            if (af) begin
                e = ref_op(op, acc_en ? m_acc : A, B);
                m_acc = e;
                exp_q.push_back(e);
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rnd_recv_count", recv, 1000);
        check("rnd_queue_empty", exp_q.size(), 0);
        in_valid = 1'b0;

        // Reset with both stages full and acc=0xAA
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, OP_PASS, 1'b0, 8'hAA, 8'h00);
        tick();
        in_valid = 1'b0;
        tick();
        check("mr_acc_seed", C, 8'hAA);
        out_ready = 1'b0;
        drive(1'b1, OP_PASS, 1'b0, 8'hAA, 8'h00);
        tick();
        tick();
        in_valid = 1'b0;
        #1;
        check("mr_full_valid", out_valid, 1);
        check("mr_full_in_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_out_valid", out_valid, 0);
        check("mr_in_ready", in_ready, 1);
        check("mr_C", C, 0);
        out_ready = 1'b1;
        drive(1'b1, OP_OR, 1'b1, 8'h77, 8'h00);
        tick();
        in_valid = 1'b0;
        check("mr_post_not_valid", out_valid, 0);
        tick();
        check("mr_post_valid", out_valid, 1);
        check("mr_post_C", C, 8'h00);
        check("mr_post_zero", zero, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
